// File: rtl/segment_scan_ctrl.sv
// segment_scan_ctrl: scan-phase sequencer and frame buffer for the 8-phase
// 7-segment display datapath. Odd phases are lit for one sub-period. Even
// (blank) phases are stretched to dim the display. New values arrive over a
// valid/ready handshake and are committed only at frame boundaries, so the
// display never tears.
//
// Build option: define SCAN_CLAMP_EN to saturate each 6-bit field of upd_data
// to 59 when it is captured. Without it the fields are stored raw.
module segment_scan_ctrl #(
    parameter int CLK_DIV = 1000,   // clock cycles per sub-period, >= 2
    parameter int DIV_W   = 16      // prescaler width, 2**DIV_W > CLK_DIV
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [2:0]  brightness,
    input  logic        upd_valid,
    input  logic [11:0] upd_data,
    output logic        upd_ready,
    output logic [11:0] data_show,
    output logic [2:0]  byte_status,
    output logic        phase_tick,
    output logic        frame_start
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q,     div_cnt_d;
    logic [2:0]       sub_cnt_q,     sub_cnt_d;
    logic [2:0]       byte_status_q, byte_status_d;
    logic [2:0]       bright_q,      bright_d;
    logic             phase_tick_q,  phase_tick_d;
    logic             frame_start_q, frame_start_d;
    logic             enable_q,      enable_d;
    logic [11:0]      pend_q,        pend_d;
    logic             pend_full_q,   pend_full_d;
    logic [11:0]      data_show_q,   data_show_d;

    logic       sub_tick;
    logic [3:0] phase_len;
    logic       phase_last;
    logic       frame_wrap;
    logic       enable_rise;
    logic       accept;
    logic       commit;
    logic [11:0] pend_in;

    // Timing decodes: end of sub-period, end of phase, end of frame.
    always_comb begin
        sub_tick    = enable && (div_cnt_q == DIV_LAST);
        // Odd phases are lit for one sub-period; even phases last 8-bright_q.
        phase_len   = byte_status_q[0] ? 4'd1 : (4'd8 - {1'b0, bright_q});
        phase_last  = sub_tick && ({1'b0, sub_cnt_q} == (phase_len - 4'd1));
        frame_wrap  = phase_last && (byte_status_q == 3'd7);
        enable_rise = enable && !enable_q;
        accept      = upd_valid && !pend_full_q;
        // Only a full buffer commits, and only a non-full one accepts, so
        // the two never compete for pend in the same cycle.
        commit      = pend_full_q && (!enable || frame_wrap);
    end

    // Field shaping applied as data is captured into the pending buffer.
    always_comb begin
`ifdef SCAN_CLAMP_EN
        pend_in[11:6] = (upd_data[11:6] > 6'd59) ? 6'd59 : upd_data[11:6];
        pend_in[5:0]  = (upd_data[5:0]  > 6'd59) ? 6'd59 : upd_data[5:0];
`else
        pend_in = upd_data;
`endif
    end

    // Next-state logic for the scan counters, brightness latch and buffers.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        div_cnt_d     = div_cnt_q;
        sub_cnt_d     = sub_cnt_q;
        byte_status_d = byte_status_q;
        bright_d      = bright_q;
        phase_tick_d  = phase_last;
        frame_start_d = frame_wrap;
        enable_d      = enable;
        pend_d        = pend_q;
        pend_full_d   = pend_full_q;
        data_show_d   = data_show_q;

        if (!enable) begin
            // Halted: hold the scan at phase 0 with the display blank.
            div_cnt_d     = '0;
            sub_cnt_d     = '0;
            byte_status_d = '0;
        end else begin
            div_cnt_d = sub_tick ? '0 : div_cnt_q + DIV_W'(1);
            if (phase_last) begin
                sub_cnt_d     = '0;
                byte_status_d = byte_status_q + 3'd1;
            end else if (sub_tick) begin
                sub_cnt_d = sub_cnt_q + 3'd1;
            end
        end

        // Brightness only changes at a frame edge or a scan restart.
        if (enable_rise || frame_wrap) begin
            bright_d = brightness;
        end

        if (commit) begin
            data_show_d = pend_q;
            pend_full_d = 1'b0;
        end else if (accept) begin
            pend_d      = pend_in;
            pend_full_d = 1'b1;
        end
    end

    // State registers; reset clears everything, discarding pending data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_q     <= '0;
            sub_cnt_q     <= '0;
            byte_status_q <= '0;
            bright_q      <= '0;
            phase_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
            enable_q      <= 1'b0;
            pend_q        <= '0;
            pend_full_q   <= 1'b0;
            data_show_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            div_cnt_q     <= div_cnt_d;
            sub_cnt_q     <= sub_cnt_d;
            byte_status_q <= byte_status_d;
            bright_q      <= bright_d;
            phase_tick_q  <= phase_tick_d;
            frame_start_q <= frame_start_d;
            enable_q      <= enable_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            data_show_q   <= data_show_d;
        end
    end

    assign upd_ready   = ~pend_full_q;
    assign data_show   = data_show_q;
    assign byte_status = byte_status_q;
    assign phase_tick  = phase_tick_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Directed bench for segment_scan_ctrl with CLK_DIV=4. Cycle numbers in the
// tests count rising edges after reset release (cycle 1 = first edge).
module tb_segment_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  brightness;
    logic        upd_valid;
    logic [11:0] upd_data;
    logic        upd_ready;
    logic [11:0] data_show;
    logic [2:0]  byte_status;
    logic        phase_tick;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    segment_scan_ctrl #(.CLK_DIV(4), .DIV_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .brightness  (brightness),
        .upd_valid   (upd_valid),
        .upd_data    (upd_data),
        .upd_ready   (upd_ready),
        .data_show   (data_show),
        .byte_status (byte_status),
        .phase_tick  (phase_tick),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset(input logic en, input logic [2:0] br);
        reset = 1'b1; enable = en; brightness = br;
        upd_valid = 1'b0; upd_data = '0;
        step(2);
        reset = 1'b0;
    endtask

    // Cycles until the next phase_tick, bounded; an overrun counts as a failure.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (phase_tick !== 1'b1 && n < 1000);
        if (phase_tick !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_tick: no phase_tick within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; brightness = 3'd7;
        upd_valid = 1'b0; upd_data = '0;
        step(2);
        n_cmp++; if (data_show !== 12'h000) begin n_bad++; $display("FAIL rst_data_show: got %h want 000", data_show); end
        n_cmp++; if (byte_status !== 3'd0) begin n_bad++; $display("FAIL rst_byte_status: got %0d want 0", byte_status); end
        n_cmp++; if (phase_tick !== 1'b0) begin n_bad++; $display("FAIL rst_phase_tick: got %b want 0", phase_tick); end
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_frame_start: got %b want 0", frame_start); end
        n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_upd_ready: got %b want 1", upd_ready); end
    endtask

    task automatic test_reset_midframe();
        do_reset(1'b1, 3'd7);
        step(5);
        upd_valid = 1'b1; upd_data = 12'h123;
        step(1);
        upd_valid = 1'b0;
        n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_accept: ready got %b want 0", upd_ready); end
        reset = 1'b1;
        #2;
        n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", upd_ready); end
        step(1);
        reset = 1'b0;
        step(40);
        n_cmp++; if (data_show !== 12'h000) begin n_bad++; $display("FAIL midrst_discard: data_show got %h want 000", data_show); end
    endtask

    task automatic test_bright7();
        logic [2:0] exp_bs;
        logic       exp_tick, exp_fs;
        do_reset(1'b1, 3'd7);
        for (int cyc = 1; cyc <= 64; cyc++) begin
            step(1);
            exp_bs   = 3'((cyc / 4) % 8);
            exp_tick = (cyc % 4) == 0;
            exp_fs   = (cyc % 32) == 0;
            n_cmp++; if (byte_status !== exp_bs) begin n_bad++; $display("FAIL b7_byte_status c%0d: got %0d want %0d", cyc, byte_status, exp_bs); end
            n_cmp++; if (phase_tick !== exp_tick) begin n_bad++; $display("FAIL b7_phase_tick c%0d: got %b want %b", cyc, phase_tick, exp_tick); end
            n_cmp++; if (frame_start !== exp_fs) begin n_bad++; $display("FAIL b7_frame_start c%0d: got %b want %b", cyc, frame_start, exp_fs); end
        end
    endtask

    // brightness=0 for two frames (changed to 7 mid-frame 2), then frame 3 short.
    task automatic test_bright0();
        int n, exp_len;
        logic [2:0] exp_bs;
        logic exp_fs;
        do_reset(1'b1, 3'd0);
        for (int k = 0; k < 24; k++) begin
            wait_tick(n);
            exp_len = ((k % 2) == 0 && k < 16) ? 32 : 4;
            exp_bs  = 3'((k + 1) % 8);
            exp_fs  = (k % 8) == 7;
            n_cmp++; if (n !== exp_len) begin n_bad++; $display("FAIL b0_len k%0d: got %0d cycles want %0d", k, n, exp_len); end
            n_cmp++; if (byte_status !== exp_bs) begin n_bad++; $display("FAIL b0_byte_status k%0d: got %0d want %0d", k, byte_status, exp_bs); end
            n_cmp++; if (frame_start !== exp_fs) begin n_bad++; $display("FAIL b0_frame_start k%0d: got %b want %b", k, frame_start, exp_fs); end
            if (k == 8) brightness = 3'd7;
        end
    endtask

    task automatic test_update();
        int bad = 0;
        do_reset(1'b1, 3'd7);
        step(10);
        upd_valid = 1'b1; upd_data = 12'h3AB;
        step(1);
        upd_valid = 1'b0;
        n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL upd_ready_low: got %b want 0", upd_ready); end
        for (int cyc = 12; cyc <= 31; cyc++) begin
            step(1);
            if (data_show !== 12'h000) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL upd_early_commit: %0d cycles showed new data, want 0", bad); end
        step(1);
        n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL upd_frame_start: got %b want 1", frame_start); end
        n_cmp++; if (data_show !== 12'h3AB) begin n_bad++; $display("FAIL upd_commit: got %h want 3ab", data_show); end
        n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL upd_ready_back: got %b want 1", upd_ready); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1, 3'd7);
        step(5);
        upd_valid = 1'b1; upd_data = 12'h155;
        step(1);                                     // cycle 6: A accepted
        upd_data = 12'h2CC;                          // B offered, held
        n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold6: ready got %b want 0", upd_ready); end
        step(25);                                    // cycle 31
        n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold31: ready got %b want 0", upd_ready); end
        n_cmp++; if (data_show !== 12'h000) begin n_bad++; $display("FAIL b2b_pre: data_show got %h want 000", data_show); end
        step(1);                                     // cycle 32: boundary
        n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL b2b_fs32: got %b want 1", frame_start); end
        n_cmp++; if (data_show !== 12'h155) begin n_bad++; $display("FAIL b2b_commitA: got %h want 155", data_show); end
        n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready32: got %b want 1", upd_ready); end
        step(1);                                     // cycle 33: B accepted
        upd_valid = 1'b0;
        n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_acceptB: ready got %b want 0", upd_ready); end
        n_cmp++; if (data_show !== 12'h155) begin n_bad++; $display("FAIL b2b_holdA: got %h want 155", data_show); end
        step(31);                                    // cycle 64
        n_cmp++; if (data_show !== 12'h2CC) begin n_bad++; $display("FAIL b2b_commitB: got %h want 2cc", data_show); end
        n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready64: got %b want 1", upd_ready); end
        step(31);                                    // cycle 95: boundary cycle
        upd_valid = 1'b1; upd_data = 12'h0F0;
        step(1);                                     // cycle 96: C taken at boundary
        upd_valid = 1'b0;
        n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL b2b_fs96: got %b want 1", frame_start); end
        n_cmp++; if (data_show !== 12'h2CC) begin n_bad++; $display("FAIL b2b_boundary_keep: got %h want 2cc", data_show); end
        n_cmp++; if (upd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_boundary_accept: ready got %b want 0", upd_ready); end
        step(32);                                    // cycle 128
        n_cmp++; if (data_show !== 12'h0F0) begin n_bad++; $display("FAIL b2b_commitC: got %h want 0f0", data_show); end
    endtask

    task automatic test_disable();
        int bad = 0;
        do_reset(1'b1, 3'd7);
        step(5);
        upd_valid = 1'b1; upd_data = 12'h041;
        step(1);                                     // cycle 6: accepted
        upd_valid = 1'b0;
        enable = 1'b0;
        step(1);                                     // cycle 7
        n_cmp++; if (byte_status !== 3'd0) begin n_bad++; $display("FAIL dis_blank: byte_status got %0d want 0", byte_status); end
        n_cmp++; if (data_show !== 12'h041) begin n_bad++; $display("FAIL dis_commit: got %h want 041", data_show); end
        n_cmp++; if (upd_ready !== 1'b1) begin n_bad++; $display("FAIL dis_ready: got %b want 1", upd_ready); end
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (phase_tick !== 1'b0 || frame_start !== 1'b0 || byte_status !== 3'd0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL dis_quiet: %0d active cycles, want 0", bad); end
        brightness = 3'd3;
        enable = 1'b1;
        bad = 0;
        for (int i = 0; i < 19; i++) begin
            step(1);
            if (phase_tick !== 1'b0 || frame_start !== 1'b0 || byte_status !== 3'd0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL en_restart_phase0: %0d early-tick cycles, want 0", bad); end
        step(1);                                     // 20 = 4*(8-3) cycles after rise
        n_cmp++; if (phase_tick !== 1'b1) begin n_bad++; $display("FAIL en_first_tick: got %b want 1", phase_tick); end
        n_cmp++; if (byte_status !== 3'd1) begin n_bad++; $display("FAIL en_byte_status: got %0d want 1", byte_status); end
        n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL en_no_frame_start: got %b want 0", frame_start); end
    endtask

    task automatic test_clamp();
        logic [11:0] exp_a, exp_b;
`ifdef SCAN_CLAMP_EN
        exp_a = 12'hEFB;
        exp_b = 12'hEFA;
`else
        exp_a = 12'hFFF;
        exp_b = 12'hF3A;
`endif
        do_reset(1'b1, 3'd7);
        step(5);
        upd_valid = 1'b1; upd_data = 12'hFFF;
        step(1);
        upd_valid = 1'b0;
        step(26);                                    // cycle 32
        n_cmp++; if (data_show !== exp_a) begin n_bad++; $display("FAIL clamp_fff: got %h want %h", data_show, exp_a); end
        upd_valid = 1'b1; upd_data = 12'hF3A;
        step(1);
        upd_valid = 1'b0;
        step(31);                                    // cycle 64
        n_cmp++; if (data_show !== exp_b) begin n_bad++; $display("FAIL clamp_f3a: got %h want %h", data_show, exp_b); end
    endtask

    initial begin
        test_reset();
        test_reset_midframe();
        test_bright7();
        test_bright0();
        test_update();
        test_back_to_back();
        test_disable();
        test_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
